// File: rtl/div_sched.sv
// Sequencer for the shared multi-cycle divider: launch, watchdog, flush-cancel and result hold for EXE.
// Optional DIV_FASTPATH_EN: divisors 0 and 1 are resolved locally without launching the core.
module div_sched #(
    parameter int MAX_CYC = 40,
    parameter int CNT_W   = 6
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        div_req,
    input  logic [1:0]  div_op,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    input  logic        flush,
    input  logic        ms_allow_in,
    output logic        core_start,
    output logic        core_signed,
    output logic [31:0] core_src1,
    output logic [31:0] core_src2,
    output logic        core_cancel,
    input  logic        core_done,
    input  logic [31:0] core_q,
    input  logic [31:0] core_r,
    output logic        div_busy,
    output logic        div_valid,
    output logic [31:0] div_result,
    output logic        div_timeout
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_op_mod;
    logic [31:0]       r_result;

    logic              w_launch;
    logic              w_fast;
    logic [31:0]       w_fast_val;
    logic              w_start;
    logic              w_cancel;
    logic              w_timeout;
    logic              w_load;
    logic [31:0]       w_load_val;
    logic              w_cnt_last;

    assign w_launch   = (r_state == S_IDLE) && div_req && !flush;
    assign w_cnt_last = (r_cnt == CNT_W'(MAX_CYC - 1));

`ifdef DIV_FASTPATH_EN
    // src2==0: q=all ones, r=src1; src2==1: q=src1, r=0
    assign w_fast     = (src2[31:1] == 31'd0);
    assign w_fast_val = div_op[0] ? (src2[0] ? 32'd0 : src1)
                                  : (src2[0] ? src1 : 32'hFFFF_FFFF);
`else
    assign w_fast     = 1'b0;
    assign w_fast_val = 32'd0;
`endif

    always_comb begin
        w_next     = r_state;
        w_start    = 1'b0;
        w_cancel   = 1'b0;
        w_timeout  = 1'b0;
        w_load     = 1'b0;
        w_load_val = r_result;
        case (r_state)
            S_IDLE: begin
                if (w_launch) begin
                    if (w_fast) begin
                        w_load     = 1'b1;
                        w_load_val = w_fast_val;
                        w_next     = S_HOLD;
                    end else begin
                        w_start = 1'b1;
                        w_next  = S_RUN;
                    end
                end
            end
            S_RUN: begin
                // flush outranks a same-cycle core_done; that result is dropped
                if (flush) begin
                    w_cancel = 1'b1;
                    w_next   = S_IDLE;
                end else if (core_done) begin
                    w_load     = 1'b1;
                    w_load_val = r_op_mod ? core_r : core_q;
                    w_next     = S_HOLD;
                end else if (w_cnt_last) begin
                    w_cancel   = 1'b1;
                    w_timeout  = 1'b1;
                    w_load     = 1'b1;
                    w_load_val = 32'd0;
                    w_next     = S_HOLD;
                end
            end
            S_HOLD: begin
                if (ms_allow_in || flush) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_op_mod <= 1'b0;
            r_result <= 32'd0;
        end else begin
            r_state <= w_next;
            if (w_launch) begin
                r_op_mod <= div_op[0];
                r_cnt    <= '0;
            end else if (r_state == S_RUN && r_cnt != {CNT_W{1'b1}}) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_load) begin
                r_result <= w_load_val;
            end
        end
    end

    assign core_start  = w_start && resetn;
    assign core_cancel = w_cancel && resetn;
    assign core_signed = !div_op[1];
    assign core_src1   = src1;
    assign core_src2   = src2;
    assign div_busy    = (r_state != S_IDLE);
    assign div_valid   = !div_req || (r_state == S_HOLD);
    assign div_result  = r_result;
    assign div_timeout = w_timeout;

endmodule
